// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text scheduler: FSM state encoding,
// HD44780 command constants and nibble delay values derived from the clock.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_IDLE      = 3'd2,
    ST_ADDR_HI   = 3'd3,
    ST_ADDR_LO   = 3'd4,
    ST_CHAR_HI   = 3'd5,
    ST_CHAR_LO   = 3'd6
  } sched_state_t;

  localparam int unsigned LCD_FREQ = 50_000_000;
  localparam int unsigned t1_uS    = LCD_FREQ / 1_000_000;
  localparam int unsigned t10us    = 10 * t1_uS;
  localparam int unsigned t53us    = 53 * t1_uS;

  localparam logic [7:0] LCD_SET_DDRAM  = 8'h80;
  localparam logic [6:0] LCD_LINE2_BASE = 7'h40;
  localparam logic [7:0] LCD_BLANK      = 8'h20;
  localparam int unsigned LCD_COLS      = 16;

  // Convert a delay in microseconds to clock cycles for a given clock frequency.
  function automatic logic [20:0] us_to_cycles(input int unsigned freq, input int unsigned us);
    return 21'((freq / 1_000_000) * us);
  endfunction

endpackage

// File: rtl/lcd_frame_buf.sv
// 32x8 character frame buffer: line in address bit 4, column in bits 3:0.
// Synchronous write, combinational read, every cell resets to a space.
module lcd_frame_buf
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [32];

  // Storage cells: blank on reset, host byte written one cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= LCD_BLANK;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_text_scheduler.sv
// LCD text scheduler: kicks off the init sequencer, then streams dirty display
// lines (set-DDRAM-address + 16 characters) to the 4-bit transfer engine as
// high/low nibbles. Optional feature macro: LCD_AUTO_REFRESH_EN (periodic
// re-marking of both lines as dirty once the display is ready).
module lcd_text_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned FREQ           = 50_000_000,
  parameter int unsigned REFRESH_CYCLES = 25_000_000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        start_init,
  input  logic        init_done,
  output logic        cmd_send,
  output logic [3:0]  cmd_nibble,
  output logic        cmd_rs,
  output logic [20:0] cmd_delay,
  output logic        cmd_read_busy,
  input  logic        cmd_done,
  output logic        busy,
  output logic        ready
);

  localparam logic [20:0] DLY_HI = us_to_cycles(FREQ, 10);
  localparam logic [20:0] DLY_LO = us_to_cycles(FREQ, 53);

  sched_state_t state, state_next;
  logic [1:0]  dirty, dirty_set, dirty_clr;
  logic        line, line_next;
  logic [3:0]  idx, idx_next;
  logic [7:0]  char_byte, char_byte_next;
  logic [7:0]  rd_data, addr_byte;
  logic        send_next, rs_next, rb_next, start_next, ready_next, busy_next;
  logic [3:0]  nibble_next;
  logic [20:0] delay_next;
  logic [3:0]  pres_nibble;
  logic        pres_rs, pres_hi;

  lcd_frame_buf u_buf (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr ({line, idx}),
    .rd_data (rd_data)
  );

  assign addr_byte = LCD_SET_DDRAM | {1'b0, (line ? LCD_LINE2_BASE : 7'h00)};

`ifdef LCD_AUTO_REFRESH_EN
  logic [31:0] refresh_cnt;
  logic        refresh_wrap;

  assign refresh_wrap = (refresh_cnt == 32'(REFRESH_CYCLES - 1));

  // Free-running refresh period counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      refresh_cnt <= 32'd0;
    end else if (refresh_wrap) begin
      refresh_cnt <= 32'd0;
    end else begin
      refresh_cnt <= refresh_cnt + 32'd1;
    end
  end

  // Lines marked dirty by host writes and by the periodic refresh.
  always_comb begin
    dirty_set = 2'b00;
    if (wr_en) begin
      dirty_set[wr_addr[4]] = 1'b1;
    end else begin
      dirty_set = 2'b00;
    end
    if (refresh_wrap && ready) begin
      dirty_set = 2'b11;
    end else begin
      dirty_set = dirty_set;
    end
  end
`else
  // Lines marked dirty by host writes.
  always_comb begin
    dirty_set = 2'b00;
    if (wr_en) begin
      dirty_set[wr_addr[4]] = 1'b1;
    end else begin
      dirty_set = 2'b00;
    end
  end
`endif

  // Nibble fields each send state presents to the transfer engine.
  always_comb begin
    pres_nibble = 4'h0;
    pres_rs     = 1'b0;
    pres_hi     = 1'b0;
    case (state)
      ST_ADDR_HI: begin pres_nibble = addr_byte[7:4]; pres_rs = 1'b0; pres_hi = 1'b1; end
      ST_ADDR_LO: begin pres_nibble = addr_byte[3:0]; pres_rs = 1'b0; pres_hi = 1'b0; end
      ST_CHAR_HI: begin pres_nibble = rd_data[7:4];   pres_rs = 1'b1; pres_hi = 1'b1; end
      ST_CHAR_LO: begin pres_nibble = char_byte[3:0]; pres_rs = 1'b1; pres_hi = 1'b0; end
      default:    begin pres_nibble = 4'h0;           pres_rs = 1'b0; pres_hi = 1'b0; end
    endcase
  end

  // Next-state and next-output logic; a send state first presents its nibble,
  // then waits for cmd_done, drops cmd_send for one cycle and moves on.
  always_comb begin
    state_next     = state;
    send_next      = cmd_send;
    nibble_next    = cmd_nibble;
    rs_next        = cmd_rs;
    delay_next     = cmd_delay;
    rb_next        = cmd_read_busy;
    start_next     = 1'b0;
    ready_next     = ready;
    line_next      = line;
    idx_next       = idx;
    char_byte_next = char_byte;
    dirty_clr      = 2'b00;
    case (state)
      ST_BOOT: begin
        state_next = ST_WAIT_INIT;
        start_next = 1'b1;
      end
      ST_WAIT_INIT: begin
        if (init_done) begin
          state_next = ST_IDLE;
          ready_next = 1'b1;
        end else begin
          state_next = ST_WAIT_INIT;
        end
      end
      ST_IDLE: begin
        if (dirty[0]) begin
          line_next  = 1'b0;
          dirty_clr  = 2'b01;
          idx_next   = 4'd0;
          state_next = ST_ADDR_HI;
        end else if (dirty[1]) begin
          line_next  = 1'b1;
          dirty_clr  = 2'b10;
          idx_next   = 4'd0;
          state_next = ST_ADDR_HI;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ADDR_HI, ST_ADDR_LO, ST_CHAR_HI, ST_CHAR_LO: begin
        if (!cmd_send) begin
          send_next   = 1'b1;
          nibble_next = pres_nibble;
          rs_next     = pres_rs;
          delay_next  = pres_hi ? DLY_HI : DLY_LO;
          rb_next     = ~pres_hi;
          if (state == ST_CHAR_HI) begin
            char_byte_next = rd_data;
          end else begin
            char_byte_next = char_byte;
          end
        end else if (cmd_done) begin
          send_next = 1'b0;
          case (state)
            ST_ADDR_HI: state_next = ST_ADDR_LO;
            ST_ADDR_LO: state_next = ST_CHAR_HI;
            ST_CHAR_HI: state_next = ST_CHAR_LO;
            ST_CHAR_LO: begin
              if (idx == 4'(LCD_COLS - 1)) begin
                state_next = ST_IDLE;
              end else begin
                idx_next   = idx + 4'd1;
                state_next = ST_CHAR_HI;
              end
            end
            default: state_next = ST_IDLE;
          endcase
        end else begin
          send_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_BOOT;
        send_next  = 1'b0;
      end
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  // State, dirty flags and registered outputs; reset aborts any transfer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= ST_BOOT;
      dirty         <= 2'b11;
      line          <= 1'b0;
      idx           <= 4'd0;
      char_byte     <= 8'h00;
      start_init    <= 1'b0;
      cmd_send      <= 1'b0;
      cmd_nibble    <= 4'h0;
      cmd_rs        <= 1'b0;
      cmd_delay     <= 21'd0;
      cmd_read_busy <= 1'b0;
      busy          <= 1'b0;
      ready         <= 1'b0;
    end else begin
      state         <= state_next;
      dirty         <= (dirty & ~dirty_clr) | dirty_set;
      line          <= line_next;
      idx           <= idx_next;
      char_byte     <= char_byte_next;
      start_init    <= start_next;
      cmd_send      <= send_next;
      cmd_nibble    <= nibble_next;
      cmd_rs        <= rs_next;
      cmd_delay     <= delay_next;
      cmd_read_busy <= rb_next;
      busy          <= busy_next;
      ready         <= ready_next;
    end
  end

endmodule
